// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity-mode encodings,
// transmitter FSM state encoding and the parity helper functions.
package uart_pkg;

   // Widest data word the transmitter supports.
   localparam int MAX_DATA_W = 8;

   // Parity-mode encodings as driven on the parity_mode port.
   typedef enum logic [1:0] {
      PAR_NONE   = 2'b00,
      PAR_ODD    = 2'b01,
      PAR_EVEN   = 2'b10,
      PAR_NONE_B = 2'b11
   } parity_e;

   // Transmitter FSM states, in the order they appear on the line.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // True when the mode inserts a parity bit into the frame.
   function automatic logic parity_enabled(input parity_e mode);
      return (mode == PAR_ODD) || (mode == PAR_EVEN);
   endfunction

   // Parity bit for a data word; unused upper bits must be zero so they
   // do not disturb the XOR reduction.
   function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                       input parity_e mode);
      logic p;
      case (mode)
         PAR_ODD:  p = ~(^data);
         PAR_EVEN: p = ^data;
         default:  p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy counter.
// The head word is presented combinationally so the consumer can take it
// in the same cycle it asserts rd_en.
module uart_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [AW:0]       usedw,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic              wr_ok;
   logic              rd_ok;

   // Full/empty come from the pre-edge count, so a pop in the same cycle
   // never lets a write into a full FIFO.
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign wr_ok   = wr_en & ~full;
   assign rd_ok   = rd_en & ~empty;
   assign usedw   = count_reg;
   assign rd_data = mem[rd_ptr_reg];

   // Storage array: written only when the write is accepted.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_gen.sv
// Buffered UART transmitter: words are queued in a FIFO and sent as
// start / data (LSB first) / optional parity / 1-2 stop bits, each bit
// lasting DIV clock cycles. Frames from a non-empty FIFO follow each other
// with no idle gap. Txd is registered and idles high.
module uart_tx_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic              SYS_CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_en,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   input  logic              ovf_clr,
   output logic              Txd,
   output logic              tx_busy,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       usedw,
   output logic              overflow
);

   localparam int DIV = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV);

   // FIFO interface
   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;

   // Transmitter state
   tx_state_e         state_reg,  state_next;
   logic [CW-1:0]     cnt_reg,    cnt_next;
   logic [2:0]        bit_reg,    bit_next;
   logic [DATA_W-1:0] word_reg,   word_next;
   parity_e           mode_reg,   mode_next;
   logic              stop2_reg,  stop2_next;
   logic              txd_reg,    txd_next;
   logic              overflow_reg;

   logic              cnt_last;
   logic [MAX_DATA_W-1:0] word_ext;

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (SYS_CLK),
      .rst     (RST),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .usedw   (usedw),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign full     = fifo_full;
   assign empty    = fifo_empty;
   assign Txd      = txd_reg;
   assign tx_busy  = (state_reg != ST_IDLE);
   assign overflow = overflow_reg;
   assign cnt_last = (cnt_reg == CW'(DIV - 1));

   // Next-state logic: bit sequencing on baud-counter wrap, plus loading of
   // the next word (and its config) whenever a new frame begins.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      word_next  = word_reg;
      mode_next  = mode_reg;
      stop2_next = stop2_reg;
      pop        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
            end
         end
         ST_START: begin
            if (cnt_last) begin
               state_next = ST_DATA;
               cnt_next   = '0;
               bit_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_last) begin
               cnt_next = '0;
               if (bit_reg == 3'(DATA_W - 1)) begin
                  bit_next   = '0;
                  state_next = parity_enabled(mode_reg) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_PARITY: begin
            if (cnt_last) begin
               state_next = ST_STOP;
               cnt_next   = '0;
               bit_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_last) begin
               cnt_next = '0;
               if (stop2_reg && (bit_reg == 3'd0)) begin
                  // first of two stop bits done; bit_reg tracks stop index
                  bit_next = 3'd1;
               end else if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_next = ST_IDLE;
                  bit_next   = '0;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            bit_next   = '0;
         end
      endcase

      // Starting a frame: the config is captured here so later changes on
      // the ports cannot disturb the frame in flight.
      if (pop) begin
         state_next = ST_START;
         cnt_next   = '0;
         bit_next   = '0;
         word_next  = fifo_rd_data;
         mode_next  = parity_e'(parity_mode);
         stop2_next = stop2;
      end
   end

   // Line level for the upcoming cycle, so Txd can be a plain register
   // aligned with the state register.
   always_comb begin
      word_ext = MAX_DATA_W'(word_next);
      txd_next = 1'b1;
      case (state_next)
         ST_START:  txd_next = 1'b0;
         ST_DATA:   txd_next = word_ext[bit_next];
         ST_PARITY: txd_next = parity_bit(word_ext, mode_next);
         default:   txd_next = 1'b1;
      endcase
   end

   // Transmitter registers; reset abandons any frame in progress.
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         word_reg  <= '0;
         mode_reg  <= PAR_NONE;
         stop2_reg <= 1'b0;
         txd_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         word_reg  <= word_next;
         mode_reg  <= mode_next;
         stop2_reg <= stop2_next;
         txd_reg   <= txd_next;
      end
   end

   // Sticky overflow flag: a dropped write beats a same-cycle clear.
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         overflow_reg <= 1'b0;
      end else if (wr_en && fifo_full) begin
         overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
         overflow_reg <= 1'b0;
      end
   end

endmodule
